reg_bank_pp: RTL and testbench

- Parametrised register bank: DEPTH registers of WIDTH bits, one write port, two registered read ports.
- Next generation of the fixed 32-bit register and pattern-reset register: adds a per-bank reset pattern, optional hard-zero register 0, same-cycle write-to-read bypass, and safe handling of out-of-range addresses.
- Sits between the decode stage and the ALU as the datapath register file; also usable as a generic small storage array.

---
 rtl/reg_bank_pp.sv | 203 ++++++++++++++++++++
 tb/tb_reg_bank_pp.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_pp.sv
// reg_bank_pp: parametrised register file with one write port and two
// registered read ports. Storage is built bit-by-bit from a 1-bit register
// with a load mux; write and read selection use one-hot address decoders.
// Reads see a same-edge write to the same legal address (bypass), addresses
// at or above DEPTH read as 0 and are never written, and register 0 can be
// made a hard zero.

// ---------------------------------------------------------------------------
// 1-bit storage element: synchronous active-low reset to a per-bit value,
// otherwise a load mux selects between new data and the held value.
// ---------------------------------------------------------------------------
module reg_bank_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic load,
    input  logic d,
    output logic q
);

    logic d_nxt;

    assign d_nxt = load ? d : q;

    // Reset wins; otherwise take the load-mux output every edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= rst_val;
        end else begin
            q <= d_nxt;
        end
    end

endmodule

// ---------------------------------------------------------------------------
// One-hot address decoder. Only the first DEPTH codes have an output line,
// so an out-of-range address selects nothing.
// ---------------------------------------------------------------------------
module reg_bank_dec #(
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DEPTH-1:0]      sel
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_line
        assign sel[i] = en && (addr == ADDR_WIDTH'(i));
    end

endmodule

// ---------------------------------------------------------------------------
// Read value resolver for one port. sel is the one-hot read select; a line
// that is also being written this edge returns the incoming write data.
// No select line (address out of range) resolves to 0.
// ---------------------------------------------------------------------------
module reg_bank_rd_mux #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic [DEPTH-1:0]            sel,
    input  logic [DEPTH-1:0]            we,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [DEPTH-1:0][WIDTH-1:0] regs,
    output logic [WIDTH-1:0]            value
);

    // AND-OR mux over the one-hot select, with write-data bypass per line.
    always_comb begin
        value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                value = value | (we[i] ? wdata : regs[i]);
            end
        end
    end

endmodule

// ---------------------------------------------------------------------------
// Top level register bank.
// ---------------------------------------------------------------------------
module reg_bank_pp #(
    parameter int          WIDTH         = 32,
    parameter int          DEPTH         = 32,
    parameter int          ADDR_WIDTH    = 5,
    parameter logic [31:0] RESET_PATTERN = 32'h00000000,
    parameter int          ZERO_REG0     = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [WIDTH-1:0]      DATA_W,
    input  logic                  READ,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    output logic [WIDTH-1:0]      DATA_R1,
    output logic [WIDTH-1:0]      DATA_R2
);

    // Reset pattern fitted to the data width.
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_PATTERN);

    // Lines that may accept a write; register 0 is excluded when hard-zero.
    localparam logic [DEPTH-1:0] WR_MASK =
        (ZERO_REG0 != 0) ? ~DEPTH'(1) : {DEPTH{1'b1}};

    logic [DEPTH-1:0]            wr_sel;
    logic [DEPTH-1:0]            we;
    logic [DEPTH-1:0]            rd1_sel;
    logic [DEPTH-1:0]            rd2_sel;
    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]            val1;
    logic [WIDTH-1:0]            val2;

    // Write decode: only legal, in-range writes raise a line, so the same
    // vector also gates bypass and a dropped write is never forwarded.
    reg_bank_dec #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_wr_dec (
        .en   (WRITE),
        .addr (ADDR_W),
        .sel  (wr_sel)
    );

    assign we = wr_sel & WR_MASK;

    // Storage array.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if ((ZERO_REG0 != 0) && (i == 0)) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_store
            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                reg_bank_bit u_bit (
                    .clk     (CLK),
                    .rst_n   (RESET),
                    .rst_val (RST_VAL[b]),
                    .load    (we[i]),
                    .d       (DATA_W[b]),
                    .q       (regs[i][b])
                );
            end
        end
    end

    // Read decode for both ports.
    reg_bank_dec #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rd1_dec (
        .en   (1'b1),
        .addr (ADDR_R1),
        .sel  (rd1_sel)
    );

    reg_bank_dec #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rd2_dec (
        .en   (1'b1),
        .addr (ADDR_R2),
        .sel  (rd2_sel)
    );

    reg_bank_rd_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rd1_mux (
        .sel   (rd1_sel),
        .we    (we),
        .wdata (DATA_W),
        .regs  (regs),
        .value (val1)
    );

    reg_bank_rd_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rd2_mux (
        .sel   (rd2_sel),
        .we    (we),
        .wdata (DATA_W),
        .regs  (regs),
        .value (val2)
    );

    // Registered read outputs: cleared on reset, updated only when READ=1.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            DATA_R1 <= '0;
            DATA_R2 <= '0;
        end else if (READ) begin
            DATA_R1 <= val1;
            DATA_R2 <= val2;
        end
    end

endmodule

// File: tb/tb_reg_bank_pp.sv
// Testbench for reg_bank_pp: directed scenarios followed by randomized
// traffic checked against a behavioural model of the register bank.
module tb_reg_bank_pp;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 20;
    localparam int          AW    = 5;
    localparam logic [31:0] PAT   = 32'hA5A5A5A5;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          WRITE;
    logic [AW-1:0] ADDR_W;
    logic [31:0]   DATA_W;
    logic          READ;
    logic [AW-1:0] ADDR_R1;
    logic [AW-1:0] ADDR_R2;
    logic [31:0]   DATA_R1;
    logic [31:0]   DATA_R2;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: register contents and expected port outputs.
    logic [31:0] mem [DEPTH];
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;

    reg_bank_pp #(
        .WIDTH         (WIDTH),
        .DEPTH         (DEPTH),
        .ADDR_WIDTH    (AW),
        .RESET_PATTERN (PAT),
        .ZERO_REG0     (1)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .WRITE   (WRITE),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .READ    (READ),
        .ADDR_R1 (ADDR_R1),
        .ADDR_R2 (ADDR_R2),
        .DATA_R1 (DATA_R1),
        .DATA_R2 (DATA_R2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value a read of address a sees on an edge with the given write inputs.
    function automatic logic [31:0] ref_value(int a, bit wr, int aw, logic [31:0] dw);
        if (a >= DEPTH) return 32'h0;
        if (a == 0)     return 32'h0;
        if (wr && aw == a) return dw;
        return mem[a];
    endfunction

    // Drive one cycle, advance the model over the edge, settle past the edge.
    task automatic step(input bit rst_n, input bit wr, input int aw, input logic [31:0] dw,
                        input bit rd, input int a1, input int a2);
        logic [31:0] v1;
        logic [31:0] v2;
        RESET   = rst_n;
        WRITE   = wr;
        ADDR_W  = AW'(aw);
        DATA_W  = dw;
        READ    = rd;
        ADDR_R1 = AW'(a1);
        ADDR_R2 = AW'(a2);
        @(posedge CLK);
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = (i == 0) ? 32'h0 : PAT;
            exp_r1 = 32'h0;
            exp_r2 = 32'h0;
        end else begin
            v1 = ref_value(a1, wr, aw, dw);
            v2 = ref_value(a2, wr, aw, dw);
            if (rd) begin
                exp_r1 = v1;
                exp_r2 = v2;
            end
            if (wr && aw < DEPTH && aw != 0) mem[aw] = dw;
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; WRITE = 1'b0; ADDR_W = '0; DATA_W = '0;
        READ = 1'b0; ADDR_R1 = '0; ADDR_R2 = '0;

        // Reset with WRITE/READ asserted: both outputs clear.
        step(0, 1, 4, 32'h5555AAAA, 1, 4, 4);
        check("rst_r1", DATA_R1, 32'h0);
        check("rst_r2", DATA_R2, 32'h0);

        // Hard-zero r0 and pattern in r7.
        step(1, 0, 0, 32'h0, 1, 0, 7);
        check("rst_r0", DATA_R1, 32'h00000000);
        check("rst_r7", DATA_R2, PAT);

        // Write then read.
        step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        step(1, 0, 0, 32'h0, 1, 5, 6);
        check("wr_r5", DATA_R1, 32'hDEADBEEF);
        check("rd_r6", DATA_R2, PAT);

        // Bypass on both ports, then plain re-read.
        step(1, 1, 3, 32'h11111111, 0, 0, 0);
        step(1, 1, 3, 32'h22222222, 1, 3, 3);
        check("byp_r1", DATA_R1, 32'h22222222);
        check("byp_r2", DATA_R2, 32'h22222222);
        step(1, 0, 0, 32'h0, 1, 3, 1);
        check("byp_after", DATA_R1, 32'h22222222);

        // Register 0 ignores writes, including in the bypass cycle.
        step(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
        check("r0_byp1", DATA_R1, 32'h0);
        check("r0_byp2", DATA_R2, 32'h0);
        step(1, 0, 0, 32'h0, 1, 0, 0);
        check("r0_after", DATA_R1, 32'h0);

        // Out-of-range write dropped and not forwarded; no aliasing.
        step(1, 1, 25, 32'hCAFEF00D, 1, 25, 5);
        check("oor_byp", DATA_R1, 32'h0);
        check("oor_r5", DATA_R2, 32'hDEADBEEF);
        step(1, 0, 0, 32'h0, 1, 9, 25);
        check("oor_r9", DATA_R1, PAT);
        check("oor_rd", DATA_R2, 32'h0);

        // READ=0 holds the outputs while addresses and storage change.
        step(1, 1, 10, 32'h12345678, 0, 0, 0);
        step(1, 0, 0, 32'h0, 1, 10, 2);
        check("hold_set", DATA_R1, 32'h12345678);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 10, 32'h0F0F0000 + k, 0, 11 + k, 10);
            check($sformatf("hold_%0d", k), DATA_R1, 32'h12345678);
        end

        // Reset on the same edge as a write: write is lost, outputs clear.
        step(0, 1, 9, 32'hBADBAD00, 1, 9, 9);
        check("mrst_r1", DATA_R1, 32'h0);
        check("mrst_r2", DATA_R2, 32'h0);
        step(1, 0, 0, 32'h0, 1, 9, 5);
        check("mrst_r9", DATA_R1, PAT);
        check("mrst_r5", DATA_R2, PAT);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit          rst_n;
            bit          wr;
            bit          rd;
            int          aw;
            int          a1;
            int          a2;
            logic [31:0] dw;
            rst_n = ($urandom_range(0, 39) != 0);
            wr    = $urandom_range(0, 1);
            rd    = ($urandom_range(0, 3) != 0);
            aw    = $urandom_range(0, 31);
            dw    = $urandom;
            a1    = ($urandom_range(0, 2) == 0) ? aw : $urandom_range(0, 31);
            a2    = ($urandom_range(0, 2) == 0) ? aw : $urandom_range(0, 31);
            step(rst_n, wr, aw, dw, rd, a1, a2);
            check($sformatf("rnd%0d_r1", n), DATA_R1, exp_r1);
            check($sformatf("rnd%0d_r2", n), DATA_R2, exp_r2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
